config_port_arbiter: RTL

Sequenced arbiter that shares the single fabric configuration write port (ConfigFSM input) between the JTAG, UART, BitBang and CPU self-write sources. It replaces static priority muxing with session-based arbitration: a winner is locked for a whole bitstream session, ConfigFSM receives a one-cycle FSM_Reset pulse at each session start, and the block counts accepted words and flags strobes from non-granted sources. It sits between the configuration port front-ends and ConfigFSM, in the CLK domain; all inputs are already synchronous to CLK.

---
 rtl/config_arb_pkg.sv | 29 ++
 rtl/config_arb_idle_timer.sv | 31 +++
 rtl/config_port_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/config_arb_pkg.sv
// Shared types for the configuration-port arbiter: session states, grant bit
// positions and the fixed-priority one-hot encoder.
package config_arb_pkg;

  localparam int NUM_SRC       = 4;
  localparam int GRANT_JTAG    = 3;
  localparam int GRANT_UART    = 2;
  localparam int GRANT_BITBANG = 1;
  localparam int GRANT_SELF    = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    ACTIVE  = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  // Higher bit index means higher priority, so the last set bit wins.
  function automatic logic [NUM_SRC-1:0] prio_onehot(input logic [NUM_SRC-1:0] req);
    prio_onehot = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (req[i]) begin
        prio_onehot    = '0;
        prio_onehot[i] = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/config_arb_idle_timer.sv
// Saturating idle counter for CPU self-write sessions; expire_o rises on the
// IdleTimeout-th consecutive cycle without a clear.
module config_arb_idle_timer #(
  parameter int IdleTimeout  = 255,
  parameter int TimeoutWidth = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic expire_o
);

  logic [TimeoutWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (cnt_q != '1)
      cnt_d = cnt_q + TimeoutWidth'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // cnt_q == N-1 in the Nth quiet cycle after the clearing strobe.
  assign expire_o = (cnt_q >= TimeoutWidth'(IdleTimeout - 1));

endmodule

// File: rtl/config_port_arbiter.sv
// Session arbiter for the shared ConfigFSM write port (JTAG > UART > BitBang > Self).
// Optional build macro CONFIG_ARB_PREEMPT_EN lets a higher-priority request restart the session.
module config_port_arbiter
  import config_arb_pkg::*;
#(
  parameter int IdleTimeout  = 255,
  parameter int TimeoutWidth = 8,
  parameter int CountWidth   = 16
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  JTAGActive,
  input  logic                  JTAGWriteStrobe,
  input  logic [31:0]           JTAGWriteData,
  input  logic                  UART_ComActive,
  input  logic                  UART_WriteStrobe,
  input  logic [31:0]           UART_WriteData,
  input  logic                  BitBangActive,
  input  logic                  BitBangWriteStrobe,
  input  logic [31:0]           BitBangWriteData,
  input  logic                  SelfWriteStrobe,
  input  logic [31:0]           SelfWriteData,
  input  logic                  DropClear,
  output logic [31:0]           ConfigWriteData,
  output logic                  ConfigWriteStrobe,
  output logic                  FSM_Reset,
  output logic [3:0]            Grant,
  output logic                  Busy,
  output logic [CountWidth-1:0] WordCount,
  output logic                  DropFlag
);

  arb_state_e                 state_q, state_d;
  logic [NUM_SRC-1:0]         grant_q, grant_d;
  logic [NUM_SRC-1:0]         req, stb, win, ok_mask;
  logic [NUM_SRC-1:0][31:0]   wdata;
  logic                       self_expire, session_start, sel_stb;
  logic [31:0]                sel_data;
  logic                       out_stb_q, out_stb_d, pend_vld_q, pend_vld_d;
  logic [31:0]                out_data_q, out_data_d, pend_data_q, pend_data_d;
  logic [CountWidth-1:0]      cnt_q, cnt_d;
  logic                       drop_q, drop_d;

  assign stb   = {JTAGWriteStrobe, UART_WriteStrobe, BitBangWriteStrobe, SelfWriteStrobe};
  assign wdata = {JTAGWriteData, UART_WriteData, BitBangWriteData, SelfWriteData};
  assign req   = {JTAGActive, UART_ComActive, BitBangActive,
                  SelfWriteStrobe | (grant_q[GRANT_SELF] & ~self_expire)};
  assign win   = prio_onehot(req);

  config_arb_idle_timer #(
    .IdleTimeout (IdleTimeout),
    .TimeoutWidth(TimeoutWidth)
  ) u_idle_timer (
    .clk_i   (CLK),
    .rst_i   (reset),
    .clr_i   (SelfWriteStrobe),
    .expire_o(self_expire)
  );

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    session_start = 1'b0;
    case (state_q)
      IDLE: if (|req) begin
        state_d       = START;
        grant_d       = win;
        session_start = 1'b1;
      end
      START: state_d = ACTIVE;
      ACTIVE: begin
        if (~|(req & grant_q)) begin
          state_d = RELEASE;
          grant_d = '0;
        end
`ifdef CONFIG_ARB_PREEMPT_EN
        else if (win > grant_q) begin
          state_d       = START;
          grant_d       = win;
          session_start = 1'b1;
        end
`endif
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // In IDLE only the winner may strobe; its word is parked until ConfigFSM leaves reset.
  always_comb begin
    ok_mask = '0;
    if (state_q == IDLE)
      ok_mask = win;
    else if (state_q == START || state_q == ACTIVE)
      ok_mask = grant_q;
    sel_stb  = |(stb & ok_mask);
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (ok_mask[i]) sel_data = sel_data | wdata[i];

    out_stb_d   = 1'b0;
    out_data_d  = out_data_q;
    pend_vld_d  = 1'b0;
    pend_data_d = pend_data_q;
    if (state_q == IDLE) begin
      pend_vld_d = sel_stb;
      if (sel_stb) pend_data_d = sel_data;
    end else if (pend_vld_q) begin
      out_stb_d  = 1'b1;
      out_data_d = pend_data_q;
      pend_vld_d = sel_stb;
      if (sel_stb) pend_data_d = sel_data;
    end else if (sel_stb) begin
      out_stb_d  = 1'b1;
      out_data_d = sel_data;
    end

    cnt_d = cnt_q;
    if (session_start)
      cnt_d = '0;
    else if (out_stb_d && cnt_q != '1)
      cnt_d = cnt_q + CountWidth'(1);

    drop_d = drop_q;
    if (|(stb & ~ok_mask))
      drop_d = 1'b1;
    else if (DropClear)
      drop_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      out_stb_q   <= 1'b0;
      out_data_q  <= '0;
      pend_vld_q  <= 1'b0;
      pend_data_q <= '0;
      cnt_q       <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      out_stb_q   <= out_stb_d;
      out_data_q  <= out_data_d;
      pend_vld_q  <= pend_vld_d;
      pend_data_q <= pend_data_d;
      cnt_q       <= cnt_d;
      drop_q      <= drop_d;
    end
  end

  assign ConfigWriteData   = out_data_q;
  assign ConfigWriteStrobe = out_stb_q;
  assign FSM_Reset         = (state_q == START);
  assign Grant             = grant_q;
  assign Busy              = (state_q != IDLE);
  assign WordCount         = cnt_q;
  assign DropFlag          = drop_q;

endmodule
